// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential PC generation, in-order memory requests, and a small
// instruction FIFO toward decode. Redirects flush the FIFO and drop stale in-flight responses.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q;
  logic [31:0]   resp_pc_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] in_flight_q;
  logic [CW-1:0] discard_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [CW:0]   used;
  logic [31:0]   redirect_aligned;
  logic          req_fire;
  logic          resp_fire;
  logic          push;
  logic          pop;

  // Credit covers both buffered and in-flight words, so a push can never overflow.
  assign used             = {1'b0, count_q} + {1'b0, in_flight_q};
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req_valid = !rst && !redirect_valid && (used < DepthW);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is spurious and ignored.
  assign resp_fire = imem_resp_valid && (in_flight_q != '0);
  assign push      = resp_fire && (discard_q == '0) && !redirect_valid;

  assign inst_valid = !rst && (count_q != '0) && !redirect_valid;
  assign inst       = rst ? 32'h0 : data_mem[rd_ptr_q];
  assign inst_pc    = rst ? 32'h0 : pc_mem[rd_ptr_q];
  assign pop        = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      count_q     <= '0;
      in_flight_q <= '0;
      discard_q   <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      in_flight_q <= in_flight_q + CW'(req_fire) - CW'(resp_fire);
      if (redirect_valid) begin
        fetch_pc_q <= redirect_aligned;
        resp_pc_q  <= redirect_aligned;
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        // Everything still outstanding belongs to the old path; the same-cycle word is dropped.
        discard_q  <= in_flight_q - CW'(resp_fire);
      end else begin
        if (req_fire) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
        if (resp_fire && (discard_q != '0)) begin
          discard_q <= discard_q - CW'(1);
        end
        if (push) begin
          wr_ptr_q  <= wr_ptr_q + PW'(1);
          resp_pc_q <= resp_pc_q + 32'd4;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_resp_data;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: an in-order memory model with programmable latency, and a
// monitor that checks every instruction handed to decode against the expected PC queue.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int lat = 1;
  int cyc = 0;

  logic [31:0] exp_pc[$];
  logic [31:0] req_log[$];
  int          mq_due[$];
  logic [31:0] mq_addr[$];

  fetch_queue #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // In-order memory: a request accepted in cycle k answers in cycle k+lat (one word per cycle).
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_resp_valid = 1'b0;
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
        void'(mq_due.pop_front());
        imem_resp_data  = word_of(mq_addr.pop_front());
        imem_resp_valid = 1'b1;
      end
      #1;
      if (rst) begin
        mq_due.delete();
        mq_addr.delete();
        imem_resp_valid = 1'b0;
      end else if (imem_req_valid && imem_req_ready) begin
        mq_due.push_back(cyc + lat);
        mq_addr.push_back(imem_req_addr);
        req_log.push_back(imem_req_addr);
      end
    end
  end

  // Decode-side monitor: every pop is compared with the head of the expected queue.
  initial begin
    logic [31:0] p;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && inst_valid && inst_ready && exp_pc.size() > 0) begin
        p = exp_pc.pop_front();
        chk("inst_pc", inst_pc, p);
        chk("inst_data", inst, word_of(p));
      end
    end
  end

  task automatic do_reset(input bit check_outs);
    tick;
    rst = 1'b1;
    redirect_valid = 1'b0;
    exp_pc.delete();
    req_log.delete();
    if (check_outs) begin
      #1;
      chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
    end
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_pc.size() > 0 && n < 200) begin
      tick;
      n++;
    end
    total++;
    if (exp_pc.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d entries left, want 0", name, exp_pc.size());
    end
  endtask

  initial begin
    int first_iv;

    // Reset values, then streaming with 1-cycle memory.
    lat = 1;
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) exp_pc.push_back(32'(i * 4));
    #1;
    chk("t1_first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("t1_first_req_addr", imem_req_addr, 32'h0);
    first_iv = -1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        tick;
        #1;
      end
      if (inst_valid && first_iv < 0) first_iv = i;
    end
    chk("t1_inst_valid_latency", 32'(first_iv), 32'd2);
    wait_drain("t1");
    chk("t1_req0", req_log[0], 32'h0);
    chk("t1_req1", req_log[1], 32'h4);
    chk("t1_req2", req_log[2], 32'h8);

    // Decode stalled: credit stops fetch at DEPTH, then drains in order and resumes at 0x10.
    inst_ready = 1'b0;
    do_reset(1'b0);
    repeat (12) tick;
    #1;
    chk("t2_req_count", 32'(req_log.size()), 32'd4);
    chk("t2_req_valid_blocked", {31'h0, imem_req_valid}, 32'h0);
    chk("t2_inst_valid", {31'h0, inst_valid}, 32'h1);
    chk("t2_head_pc", inst_pc, 32'h0);
    chk("t2_head_data", inst, word_of(32'h0));
    tick;
    for (int i = 0; i < 6; i++) exp_pc.push_back(32'(i * 4));
    inst_ready = 1'b1;
    wait_drain("t2");
    chk("t2_resume_addr", req_log[4], 32'h10);

    // Latency 3, redirect with two requests outstanding: both stale words are dropped.
    lat = 3;
    imem_req_ready = 1'b1;
    do_reset(1'b0);
    exp_pc.push_back(32'h100);
    exp_pc.push_back(32'h104);
    exp_pc.push_back(32'h108);
    tick;
    tick;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("t3_inflight_reqs", 32'(req_log.size()), 32'd2);
    chk("t3_redirect_inst_valid", {31'h0, inst_valid}, 32'h0);
    tick;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("t3_new_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("t3_new_req_addr", imem_req_addr, 32'h100);
    wait_drain("t3");

    // Unaligned redirect coinciding with a response: that word and the buffered one vanish.
    lat = 1;
    do_reset(1'b0);
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h200);
    exp_pc.push_back(32'h204);
    exp_pc.push_back(32'h208);
    tick;
    tick;
    tick;
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    #1;
    chk("t4_redirect_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("t4_redirect_req_valid", {31'h0, imem_req_valid}, 32'h0);
    tick;
    redirect_valid = 1'b0;
    #1;
    chk("t4_new_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("t4_new_req_addr", imem_req_addr, 32'h200);
    wait_drain("t4");

    // Memory not ready for 3 cycles: address held, PC advances only on accept.
    imem_req_ready = 1'b0;
    do_reset(1'b0);
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick;
      #1;
      chk("t5_hold_valid", {31'h0, imem_req_valid}, 32'h1);
      chk("t5_hold_addr", imem_req_addr, 32'h0);
    end
    tick;
    imem_req_ready = 1'b1;
    tick;
    #1;
    chk("t5_after_accept_addr", imem_req_addr, 32'h4);
    wait_drain("t5");

    // Address wrap at the top of the space, then reset mid-stream.
    do_reset(1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    exp_pc.push_back(32'hFFFF_FFF8);
    exp_pc.push_back(32'hFFFF_FFFC);
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    tick;
    redirect_valid = 1'b0;
    wait_drain("t6");
    chk("t6_req0", req_log[0], 32'hFFFF_FFF8);
    chk("t6_req1", req_log[1], 32'hFFFF_FFFC);
    chk("t6_req2", req_log[2], 32'h0);
    repeat (2) tick;
    do_reset(1'b1);
    #1;
    chk("t6_post_rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("t6_post_rst_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("t6_post_rst_req_addr", imem_req_addr, 32'h0);
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    wait_drain("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
